// File: rtl/apb_rr_manager.sv
// apb_rr_manager: round-robin arbiter sharing one APB manager port among NumReq requesters.
// Optional ACCESS-phase timeout enabled by defining APB_RR_TIMEOUT_EN.
module apb_rr_manager #(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int NumReq        = 2,
  parameter int TimeoutCycles = 256
) (
  input  logic                        clk,
  input  logic                        nReset,
  input  logic [NumReq-1:0]           reqValid,
  input  logic [NumReq-1:0]           reqWrite,
  input  logic [NumReq*AddrWidth-1:0] reqAddr,
  input  logic [NumReq*DataWidth-1:0] reqWData,
  input  logic [NumReq*DataWidth/8-1:0] reqStrb,
  input  logic [NumReq*4-1:0]         reqProt,
  output logic [NumReq-1:0]           reqAck,
  output logic [NumReq-1:0]           respValid,
  output logic [DataWidth-1:0]        respRData,
  output logic                        respErr,
  output logic [AddrWidth-1:0]        addr,
  output logic [3:0]                  prot,
  output logic                        selector_0,
  output logic                        enable,
  output logic                        write,
  output logic [DataWidth-1:0]        wData,
  output logic [DataWidth/8-1:0]      strb,
  input  logic                        ready,
  input  logic [DataWidth-1:0]        rData,
  input  logic                        slvError
);
  localparam int SW = DataWidth / 8;
  localparam int PW = $clog2(NumReq);
  if (DataWidth != 8 && DataWidth != 16 && DataWidth != 32) begin : g_dw_chk
    $error("DataWidth must be 8, 16 or 32");
  end
  if (NumReq < 2 || NumReq > 8) begin : g_nr_chk
    $error("NumReq must be 2 to 8");
  end
  if (TimeoutCycles < 1) begin : g_to_chk
    $error("TimeoutCycles must be positive");
  end
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_nx;
  logic [PW-1:0] ptr, gnt, win, idx;
  logic any, gap, grant, fire, timeout;
`ifdef APB_RR_TIMEOUT_EN
  localparam int CW = $clog2(TimeoutCycles + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (!nReset || state != ACCESS) cnt <= '0;
    else if (!ready) cnt <= cnt + 1'b1;
  assign timeout = (cnt == CW'(TimeoutCycles)) && !ready;
`else
  assign timeout = 1'b0;
`endif
  // Descending scan so the lowest offset from ptr is the one left standing.
  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % NumReq);
      if (reqValid[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end
  // gap holds off a grant for one IDLE cycle after every response.
  assign grant = nReset && state == IDLE && any && !gap;
  assign fire  = nReset && state == ACCESS && (ready || timeout);
  assign reqAck     = grant ? NumReq'(1) << win : '0;
  assign respValid  = fire ? NumReq'(1) << gnt : '0;
  assign respRData  = (fire && ready && !write) ? rData : '0;
  assign respErr    = fire && (ready ? slvError : 1'b1);
  assign selector_0 = state != IDLE;
  assign enable     = state == ACCESS;
  always_comb begin
    state_nx = state == IDLE ? (grant ? SETUP : IDLE) :
               state == SETUP ? ACCESS : (fire ? IDLE : ACCESS);
  end
  always_ff @(posedge clk)
    if (!nReset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (!nReset) begin
      ptr   <= '0;
      gnt   <= '0;
      gap   <= 1'b0;
      addr  <= '0;
      prot  <= '0;
      write <= 1'b0;
      wData <= '0;
      strb  <= '0;
    end else begin
      gap <= fire;
      if (grant) begin
        gnt   <= win;
        addr  <= reqAddr[win*AddrWidth +: AddrWidth];
        prot  <= reqProt[win*4 +: 4];
        write <= reqWrite[win];
        wData <= reqWData[win*DataWidth +: DataWidth];
        strb  <= reqWrite[win] ? reqStrb[win*SW +: SW] : '0;
      end
      if (fire) ptr <= (gnt == PW'(NumReq - 1)) ? '0 : gnt + 1'b1;
    end
endmodule

// File: doc/apb_rr_manager.md
Name: apb_rr_manager

Overview:
- Single APB manager that shares one APB bus among NumReq local requesters using round-robin arbitration.
- Each requester presents a complete transfer (addr, write, data, strobe, prot) through a valid/ack handshake.
- The block sequences the APB IDLE/SETUP/ACCESS phases and drives the manager side of the common APB signal set (addr, prot, selector_0, enable, write, wData, strb, ready, rData, slvError).
- It returns read data and error status to the winning requester as a one-cycle response pulse.

Parameters:
- AddrWidth, 32, APB byte-address width.
- DataWidth, 32, APB data width; must be 8, 16 or 32.
- NumReq, 2, number of requesters; must be 2 to 8.
- TimeoutCycles, 256, ACCESS-phase wait limit; used only when APB_RR_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- nReset  in  1  synchronous active-low reset.
- reqValid  in  NumReq  per-requester transfer request; held until acked.
- reqWrite  in  NumReq  per-requester direction; 1 = write.
- reqAddr  in  NumReq*AddrWidth  packed addresses; requester i uses slice i.
- reqWData  in  NumReq*DataWidth  packed write data.
- reqStrb  in  NumReq*DataWidth/8  packed write strobes.
- reqProt  in  NumReq*4  packed protection attributes.
- reqAck  out  NumReq  one-hot pulse; the request was captured.
- respValid  out  NumReq  one-hot pulse; the transfer completed.
- respRData  out  DataWidth  read data, valid with respValid.
- respErr  out  1  slvError capture, valid with respValid.
- addr  out  AddrWidth  APB address.
- prot  out  4  APB protection.
- selector_0  out  1  APB select.
- enable  out  1  APB enable.
- write  out  1  APB direction.
- wData  out  DataWidth  APB write data.
- strb  out  DataWidth/8  APB write strobe.
- ready  in  1  APB ready from the peripheral.
- rData  in  DataWidth  APB read data.
- slvError  in  1  APB transfer error.

Behaviour:
- Clocking and reset: one clock, clk. nReset is synchronous and active-low.
- Reset values: every output is 0; FSM goes to IDLE; round-robin pointer = 0, so requester 0 has highest priority first.
- Reset mid-transfer: the transfer is abandoned with no respValid. selector_0 and enable drop in the cycle after the reset edge.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE, with any reqValid high:
  - Grant the first set bit found searching upward from the pointer, wrapping modulo NumReq.
  - Pulse reqAck[g] for one cycle.
  - At that edge, capture addr, write, wData, prot and strb into the APB output registers.
  - Next state is SETUP.
- IDLE, with no request: outputs hold their last values; selector_0 = 0 and enable = 0.
- SETUP: selector_0 = 1, enable = 0. Lasts exactly one cycle, then ACCESS.
- ACCESS: selector_0 = 1, enable = 1.
  - ready = 0: stay in ACCESS; all APB outputs stable.
  - ready = 1: pulse respValid[g] for one cycle.
    - respRData = rData on reads, 0 on writes.
    - respErr = slvError.
    - Pointer becomes (g+1) mod NumReq.
    - Next state is IDLE.
- Read strobes: on reads, strb is driven to 0 regardless of reqStrb.
- Latency: the reqValid rise is seen in IDLE. reqAck comes in that cycle, SETUP the next cycle, and ACCESS the cycle after. respValid comes in the ACCESS cycle where ready = 1. Minimum 3 cycles from ack to response; minimum 4 cycles per back-to-back transfer, since one IDLE cycle always separates transfers.
- Requester handshake: requester i must hold its fields stable while reqValid[i] = 1 and reqAck[i] = 0. Deasserting before ack is allowed and simply withdraws the request.
- Simultaneous requests: exactly one reqAck bit is set per grant. A non-granted requester keeps waiting. No requester waits more than NumReq-1 grants.
- Single requester: a lone requester is re-granted back-to-back, since the wrapped search finds it again.
- Inputs ignored: ready, rData and slvError are ignored outside ACCESS.

Optional Feature:
- Macro: APB_RR_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with ready = 0.
  - When it reaches TimeoutCycles, the transfer terminates: respValid[g] pulses with respErr = 1 and respRData = 0, then IDLE as normal.
  - selector_0 and enable drop on the next cycle.
  - Counter width is $clog2(TimeoutCycles+1).
- Undefined: no counter exists; ACCESS waits indefinitely for ready.

Test Plan:
- Reset: nReset = 0 for 2 cycles while reqValid = 2'b11 -> all outputs 0, no reqAck. After release, the first grant goes to requester 0.
- Single write: req0 writes addr 0x1000, wData 0xDEADBEEF, strb 4'hF; ready tied 1 -> reqAck[0] in cycle 0, SETUP (selector_0 = 1, enable = 0) in cycle 1, ACCESS in cycle 2 with respValid[0] = 1, respErr = 0, respRData = 0.
- Read with wait states: req1 reads 0x2004; ready low for 3 ACCESS cycles, then rData = 0x12345678 with ready high -> addr, write and strb = 0 stable across all 4 ACCESS cycles; respValid[1] pulses once with 0x12345678.
- Round-robin: reqValid = 2'b11 held continuously, ready = 1 -> grant order 0, 1, 0, 1 over 4 transfers, each transfer 4 cycles apart.
- Error propagation: slvError = 1 with ready = 1 on a write -> respErr = 1 in the respValid cycle; the pointer still advances.
- Timeout (APB_RR_TIMEOUT_EN defined, TimeoutCycles = 8): ready held 0 -> after 8 ACCESS cycles, respValid = 1, respErr = 1, respRData = 0; selector_0 = 0 on the following cycle.
